// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity
// helper used by both the transmitter and the receiver.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } uartState_e;

   // Parity bit a transmitter appends: even parity makes the total count of ones even
   function automatic logic calcParity(input logic [DATA_BITS-1:0] data, input logic parSel);
      return (^data) ^ (parSel == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchronizer for an asynchronous serial line; flops reset to 1
// so an idle-high line never looks like a start bit after reset.
`timescale 1ns/1ps
module uart_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8 data bits, selectable even/odd parity, one stop bit.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each bit centre.
`timescale 1ns/1ps
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 serial_in,
   input  logic                 even_odd,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int VOTE_OFS = 1;
`else
   localparam int VOTE_OFS = 0;
`endif

   // With voting the whole sampling grid sits one cycle later so the window straddles the centre
   localparam logic [CNT_W-1:0] START_SAMPLE = CNT_W'(CLKS_PER_BIT / 2 - 1 + VOTE_OFS);
   localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_BIT     = IDX_W'(DATA_BITS - 1);

   logic rxs;
   logic bitVal;

   uartState_e           state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     bitIdx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 evenOdd_q;
   logic                 parErr_q;
   logic [DATA_BITS-1:0] rxData_q;
   logic                 rxValid_q;
   logic                 parityErr_q;
   logic                 frameErr_q;
   logic                 busy_q;

   uart_bit_sync #(
      .STAGES (SYNC_STAGES)
   ) uSync (
      .clk_i   (sys_clk),
      .rst_i   (rst),
      .async_i (serial_in),
      .sync_o  (rxs)
   );

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] hist_q;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rxs};
      end
   end

   assign bitVal = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
   assign bitVal = rxs;
`endif

   // Receive FSM; a stop bit of 1 returns to IDLE mid stop bit so back-to-back frames are caught
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bitIdx_q    <= '0;
         shift_q     <= '0;
         evenOdd_q   <= PARITY_EVEN;
         parErr_q    <= 1'b0;
         rxData_q    <= '0;
         rxValid_q   <= 1'b0;
         parityErr_q <= 1'b0;
         frameErr_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rxValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxs) begin
                  state_q   <= START;
                  cnt_q     <= '0;
                  evenOdd_q <= even_odd;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == START_SAMPLE) begin
                  cnt_q <= '0;
                  if (bitVal) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q  <= DATA;
                     bitIdx_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q    <= '0;
                  shift_q  <= {bitVal, shift_q[DATA_BITS-1:1]};
                  bitIdx_q <= bitIdx_q + 1'b1;
                  if (bitIdx_q == LAST_BIT) begin
                     state_q <= PARITY;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            PARITY: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q    <= '0;
                  parErr_q <= (bitVal != calcParity(shift_q, evenOdd_q));
                  state_q  <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q       <= '0;
                  rxValid_q   <= 1'b1;
                  rxData_q    <= shift_q;
                  parityErr_q <= parErr_q;
                  frameErr_q  <= !bitVal;
                  if (bitVal) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (rxs) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data_out = rxData_q;
   assign rx_valid    = rxValid_q;
   assign parity_err  = parityErr_q;
   assign frame_err   = frameErr_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a behavioural transmitter drives serial_in,
// a negedge monitor records every rx_valid strobe.
`timescale 1ns/1ps
module tb_uart_receiver;

   localparam int CPB = 16;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic       even_odd;
   logic [7:0] rx_data_out;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   uart_receiver #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .serial_in   (serial_in),
      .even_odd    (even_odd),
      .rx_data_out (rx_data_out),
      .rx_valid    (rx_valid),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #10 sys_clk = ~sys_clk;

   typedef struct {
      logic [7:0] data;
      logic       eo;
      logic       parFlip;
      int         gapAfter;
      logic [7:0] expData;
      logic       expPe;
      logic       expFe;
   } vec_t;

   vec_t       vecs[6];
   int         compared   = 0;
   int         mismatched = 0;
   int         validCount = 0;
   int         expCount   = 0;
   logic [7:0] lastData   = 8'h00;
   logic       lastPe     = 1'b0;
   logic       lastFe     = 1'b0;
   logic       busyDropped;

   // Record every strobe; a strobe longer than one cycle shows up as an extra count
   always @(negedge sys_clk) begin
      if (rx_valid === 1'b1) begin
         validCount <= validCount + 1;
         lastData   <= rx_data_out;
         lastPe     <= parity_err;
         lastFe     <= frame_err;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic holdLine(input logic v, input int n);
      serial_in = v;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Behavioural transmitter; even_odd is flipped after the start bit to prove it is latched
   task automatic applyStimulus(input logic [7:0] d, input logic eo, input logic parFlip,
                                input logic stopBit, input int glitchBit);
      logic [10:0] frame;
      frame    = {stopBit, (^d) ^ eo ^ parFlip, d, 1'b0};
      even_odd = eo;
      for (int b = 0; b < 11; b++) begin
         if (b == 1) even_odd = ~eo;
         if (b == glitchBit) begin
            holdLine(frame[b], 8);
            holdLine(~frame[b], 1);
            holdLine(frame[b], CPB - 9);
         end else begin
            holdLine(frame[b], CPB);
         end
      end
   endtask

   task automatic waitValid(input int target, input int budget);
      for (int i = 0; i < budget && validCount < target; i++) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   initial begin
      logic [7:0] d;

      vecs[0] = '{8'hAA, 1'b0, 1'b0,  0, 8'hAA, 1'b0, 1'b0};
      vecs[1] = '{8'hCC, 1'b1, 1'b0, 20, 8'hCC, 1'b0, 1'b0};
      vecs[2] = '{8'h01, 1'b0, 1'b1, 20, 8'h01, 1'b1, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 1'b0,  0, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 20, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 30, 8'h80, 1'b1, 1'b0};

      rst       = 1'b1;
      serial_in = 1'b1;
      even_odd  = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      rst = 1'b0;
      checkOutput("reset rx_data_out", rx_data_out, 8'h00);
      checkOutput("reset rx_valid", rx_valid, 1'b0);
      checkOutput("reset parity_err", parity_err, 1'b0);
      checkOutput("reset frame_err", frame_err, 1'b0);
      checkOutput("reset busy", busy, 1'b0);
      holdLine(1'b1, 10);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].data, vecs[i].eo, vecs[i].parFlip, 1'b1, -1);
         expCount++;
         waitValid(expCount, 40);
         checkOutput($sformatf("vec%0d valid count", i), validCount, expCount);
         checkOutput($sformatf("vec%0d data", i), lastData, vecs[i].expData);
         checkOutput($sformatf("vec%0d parity_err", i), lastPe, vecs[i].expPe);
         checkOutput($sformatf("vec%0d frame_err", i), lastFe, vecs[i].expFe);
         if (vecs[i].gapAfter > 0) holdLine(1'b1, vecs[i].gapAfter);
      end
      checkOutput("held rx_data_out", rx_data_out, 8'h80);
      checkOutput("held parity_err", parity_err, 1'b1);
      checkOutput("idle busy", busy, 1'b0);

      // Short low pulse: false start, busy must clear quickly and nothing is delivered
      holdLine(1'b0, 4);
      checkOutput("pulse busy rises", busy, 1'b1);
      serial_in = 1'b1;
      for (int i = 0; i < 10 && busy === 1'b1; i++) begin
         @(posedge sys_clk);
         #1;
      end
      checkOutput("pulse busy clears", busy, 1'b0);
      holdLine(1'b1, 40);
      checkOutput("pulse no valid", validCount, expCount);

      // Stop bit 0 followed by a held break
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      expCount++;
      waitValid(expCount, 40);
      checkOutput("break valid count", validCount, expCount);
      checkOutput("break data", lastData, 8'h3C);
      checkOutput("break parity_err", lastPe, 1'b0);
      checkOutput("break frame_err", lastFe, 1'b1);
      busyDropped = 1'b0;
      for (int i = 0; i < 40; i++) begin
         holdLine(1'b0, 1);
         if (busy !== 1'b1) busyDropped = 1'b1;
      end
      checkOutput("break busy held", busyDropped, 1'b0);
      checkOutput("break no second valid", validCount, expCount);
      holdLine(1'b1, 6);
      checkOutput("break busy clears", busy, 1'b0);
      checkOutput("break frame_err held", frame_err, 1'b1);
      holdLine(1'b1, 20);

`ifdef UART_RX_MAJORITY_VOTE_EN
      holdLine(1'b0, 1);
      holdLine(1'b1, 20);
      checkOutput("vote start glitch busy", busy, 1'b0);
      checkOutput("vote start glitch no valid", validCount, expCount);
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 3);
      expCount++;
      waitValid(expCount, 40);
      checkOutput("vote glitch valid count", validCount, expCount);
      checkOutput("vote glitch data", lastData, 8'hA5);
      checkOutput("vote glitch parity_err", lastPe, 1'b0);
      holdLine(1'b1, 20);
`endif

      // Reset during data bit 3 of a 0x55 frame, then a clean 0x55
      d = 8'h55;
      even_odd = 1'b0;
      holdLine(1'b0, CPB);
      for (int b = 0; b < 3; b++) holdLine(d[b], CPB);
      holdLine(d[3], 8);
      rst       = 1'b1;
      serial_in = 1'b1;
      @(posedge sys_clk);
      #1;
      rst = 1'b0;
      checkOutput("midreset rx_data_out", rx_data_out, 8'h00);
      checkOutput("midreset rx_valid", rx_valid, 1'b0);
      checkOutput("midreset parity_err", parity_err, 1'b0);
      checkOutput("midreset frame_err", frame_err, 1'b0);
      checkOutput("midreset busy", busy, 1'b0);
      holdLine(1'b1, 40);
      checkOutput("midreset no valid", validCount, expCount);
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, -1);
      expCount++;
      waitValid(expCount, 40);
      checkOutput("post reset valid count", validCount, expCount);
      checkOutput("post reset data", lastData, 8'h55);
      checkOutput("post reset parity_err", lastPe, 1'b0);
      checkOutput("post reset frame_err", lastFe, 1'b0);
      holdLine(1'b1, 30);
      checkOutput("final valid count", validCount, expCount);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; sits directly downstream of the transmitter and consumes its serial_out line.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit (even/odd selectable), 1 stop bit (1). Line idles high.
- Recovers bytes by mid-bit sampling against an internal bit-period counter.
- Delivers each byte with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
CLKS_PER_BIT, 434, sys_clk cycles per bit period (50 MHz / 115200); must be >= 8
SYNC_STAGES, 2, flops in the serial input synchronizer; must be >= 2

Ports:
sys_clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
serial_in  input  1  asynchronous UART line, idle high
even_odd  input  1  parity select: 0 = even, 1 = odd; captured at start-bit detection
rx_data_out  output  8  received byte; held until the next rx_valid
rx_valid  output  1  one-cycle strobe for a completed frame
parity_err  output  1  parity mismatch for the frame; qualified by rx_valid
frame_err  output  1  stop bit sampled 0; qualified by rx_valid
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Interface: one clock, sys_clk. Reset rst is synchronous and active-high.
- Reset: when rst = 1 at a clock edge, the block behaves as follows:
  - state goes to IDLE; synchronizer flops are set to 1.
  - rx_data_out = 0; rx_valid, parity_err, frame_err and busy = 0.
  - A reset mid-frame aborts the frame silently; no rx_valid is issued.
- Synchronizer: serial_in passes through SYNC_STAGES flops. All decisions use the synchronized bit (rxs).
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - rxs = 0 -> START. Clear the bit counter, latch even_odd, busy = 1.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (integer division), then sample.
  - Sample 1 -> false start; return to IDLE, busy = 0.
  - Sample 0 -> DATA; restart the counter.
- DATA:
  - Sample each bit when the counter reaches CLKS_PER_BIT - 1, then restart the counter.
  - Shift in LSB first. Move to PARITY after bit index 7.
- PARITY:
  - Sample one bit.
  - Computed bit = XOR of the 8 data bits, XOR the latched even_odd.
  - A mismatch sets an internal parity error flag.
- STOP:
  - Sample the stop bit. In the following cycle:
    - rx_valid = 1 for exactly 1 cycle.
    - rx_data_out is updated.
    - parity_err = the parity result.
    - frame_err = NOT(stop bit).
  - Stop = 1 -> IDLE immediately, mid stop bit, so back-to-back frames are accepted.
  - Stop = 0 -> WAIT_HIGH.
- WAIT_HIGH: stay until rxs = 1, then IDLE. A break condition is never treated as a new start.
- Flag timing: parity_err and frame_err update only together with rx_valid and hold their value until the next rx_valid.
- Latency: rx_valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles after the serial_in falling edge, within ±1 cycle.
- busy falls in the cycle the FSM enters IDLE.
- even_odd changes mid-frame have no effect on the current frame.
- Counter width = clog2(CLKS_PER_BIT). The counter never exceeds CLKS_PER_BIT - 1.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value (start, data, parity, stop) is the 2-of-3 majority of rxs.
  - The three samples are taken at counter values mid-1, mid and mid+1.
  - The decision is made at mid+1 and the counter continues unchanged.
  - A start glitch of 1 cycle is rejected.
- Undefined: single sample at mid-point; all timing otherwise identical.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum, shared with the transmitter;
  - DATA_BITS = 8;
  - PARITY_EVEN = 0 and PARITY_ODD = 1 constants;
  - a parity function, XOR reduce plus select, reused by the transmitter.
- One sub-module, uart_bit_sync: a SYNC_STAGES-deep reset-to-1 synchronizer.
- The FSM, bit counter and shifter stay in uart_receiver.

Test Plan:
- Common bench setup: CLKS_PER_BIT = 16, 20 ns sys_clk, transmitter driving serial_in.
- 0xAA, even_odd = 0, parity bit 0 -> rx_data_out = 0xAA, rx_valid 1 cycle, parity_err = 0, frame_err = 0.
- 0xCC with even_odd = 1 (parity bit 1), sent back-to-back after 0xAA with no idle gap -> second rx_valid with 0xCC, no errors, no dropped frame.
- 0x01 with even_odd = 0 and parity bit forced to 0 -> rx_data_out = 0x01, parity_err = 1, frame_err = 0.
- 0x3C with stop bit forced to 0, line then held low for 40 cycles -> frame_err = 1. No second rx_valid. busy stays 1 until the line goes high.
- Low pulse of 4 cycles on idle line -> no rx_valid; busy returns to 0 within 10 cycles.
  - With UART_RX_MAJORITY_VOTE_EN, also a 1-cycle glitch at a data-bit mid-point -> byte unchanged.
- rst asserted 1 cycle during data bit 3 -> no rx_valid. Outputs are zero the cycle after reset. The next frame 0x55 is received correctly.
